vector_control_unit: RTL and testbench
======================================

// Module: vector_control_unit
// PURPOSE
//  Main instruction decoder of the vector ASIP datapath. Decodes the low 18 bits of
//  the fetched instruction into register-file, memory, immediate and ALU controls.
//  Sits between fetch/decode and the execute/memory stages.
//  Controls are registered: one clock of latency from Instr to outputs.
// PARAMETERS
//  INSTR_W  18  width of decoded instruction slice (fixed; fields below assume 18)
// PORTS
//  Clock       in   1  system clock, rising-edge active
//  reset       in   1  asynchronous, active-high reset
//  Instr       in   18 instruction bits [17:0]; opcode=[6:0], funct3=[14:12]
//  RegWrite    out  1  register-file write enable
//  MemWrite    out  1  data-memory write enable
//  MemToReg    out  1  1 = write-back data from memory, 0 = from ALU
//  ImmSrc      out  2  immediate format select
//  ALUSrc      out  2  ALU operand-B source select
//  RegSrc      out  2  register-read address source select
//  ALUControl  out  3  ALU operation code
// BEHAVIOUR
//  - Interface: one clock; reset asynchronous, active-high.
//  - reset=1 (async): all outputs 0 immediately; held while reset=1.
//  - Otherwise on each rising Clock edge, outputs load the decode of the current Instr.
//    Latency 1 cycle; outputs stable for the full following cycle.
//  - Decode by opcode = Instr[6:0]; funct3 = Instr[14:12]; other bits ignored.
//  - 7'b0110011 (R-type ALU):
//    RegWrite=1 MemWrite=0 MemToReg=0 ImmSrc=11 ALUSrc=00 RegSrc=00 ALUControl=funct3.
//    funct3: 000 ADD, 001 SUB, 011 MUL, 100 DIV, 101 CMP; 010/110/111 pass through unchanged.
//  - 7'b0000000 (MOV immediate):
//    RegWrite=1 MemWrite=0 MemToReg=0 ImmSrc=00 ALUSrc=11 RegSrc=00 ALUControl=funct3
//    (MOV encodes funct3=010).
//  - 7'b1111000 (LDR):
//    RegWrite=1 MemWrite=0 MemToReg=1 ImmSrc=01 ALUSrc=00 RegSrc=00 ALUControl=111
//    (address add); funct3 ignored.
//  - 7'b0000010 (STR):
//    RegWrite=0 MemWrite=1 MemToReg=0 ImmSrc=01 ALUSrc=00 RegSrc=10 ALUControl=111;
//    funct3 ignored.
//  - Any other opcode: NOP, all outputs 0. No state is corrupted, so RegWrite=MemWrite=0.
//  - Instr change mid-cycle: no effect until the next rising edge (no glitches on outputs).
//  - Reset asserted mid-stream: outputs clear at once; the first edge after release
//    decodes the Instr present then.
// TESTING
//  - reset=1 with Instr=ADD -> all outputs 0 asynchronously.
//    Release reset, edge -> ADD controls.
//  - R-type, Instr=18'h00333 (ADD) -> RegWrite=1 MemWrite=0 MemToReg=0 ImmSrc=11
//    ALUSrc=00 RegSrc=00 ALUControl=000.
//    Also SUB 18'h01333 -> 001, MUL 18'h03333 -> 011, DIV 18'h04333 -> 100,
//    CMP 18'h05333 -> 101.
//  - MOV Instr=18'b001010000010000000 -> RegWrite=1 MemToReg=0 ImmSrc=00 ALUSrc=11
//    RegSrc=00 ALUControl=010.
//  - LDR Instr=18'b010001000001111000 -> RegWrite=1 MemWrite=0 MemToReg=1 ImmSrc=01
//    ALUSrc=00 RegSrc=00 ALUControl=111.
//  - STR Instr=18'b010000000010000010 -> RegWrite=0 MemWrite=1 MemToReg=0 ImmSrc=01
//    ALUSrc=00 RegSrc=10 ALUControl=111.
//  - Unknown opcode 7'b1111111 -> all outputs 0.
//    Instr changed between edges -> outputs change only at the edge.

Source files
------------

// File: rtl/vector_control_unit.sv
// Main instruction decoder of the vector ASIP. It decodes opcode and funct3 into
// register-file, memory, immediate and ALU controls, registered with one cycle of latency.
module vector_control_unit #(
  parameter int INSTR_W = 18
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instr,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         ALUSrc,
  output logic [1:0]         RegSrc,
  output logic [2:0]         ALUControl
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_MOV   = 7'b0000000;
  localparam logic [6:0] OP_LDR   = 7'b1111000;
  localparam logic [6:0] OP_STR   = 7'b0000010;

  localparam logic [2:0] ALU_ADDR = 3'b111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = Instr[6:0];
  assign funct3            = Instr[14:12];
  assign unused_instr_bits = ^{Instr[INSTR_W-1:15], Instr[11:7]};

  logic       reg_write_d, reg_write_q;
  logic       mem_write_d, mem_write_q;
  logic       mem_to_reg_d, mem_to_reg_q;
  logic [1:0] imm_src_d, imm_src_q;
  logic [1:0] alu_src_d, alu_src_q;
  logic [1:0] reg_src_d, reg_src_q;
  logic [2:0] alu_ctrl_d, alu_ctrl_q;

  // Combinational decode; unknown opcodes fall through to an all-zero NOP.
  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    imm_src_d    = 2'b00;
    alu_src_d    = 2'b00;
    reg_src_d    = 2'b00;
    alu_ctrl_d   = 3'b000;
    unique case (opcode)
      OP_RTYPE: begin
        reg_write_d = 1'b1;
        imm_src_d   = 2'b11;
        alu_ctrl_d  = funct3;
      end
      OP_MOV: begin
        reg_write_d = 1'b1;
        alu_src_d   = 2'b11;
        alu_ctrl_d  = funct3;
      end
      OP_LDR: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
        imm_src_d    = 2'b01;
        alu_ctrl_d   = ALU_ADDR;
      end
      OP_STR: begin
        mem_write_d = 1'b1;
        imm_src_d   = 2'b01;
        reg_src_d   = 2'b10;
        alu_ctrl_d  = ALU_ADDR;
      end
      default: ;
    endcase
  end

  // Output register: outputs only move on a clock edge, never glitch mid-cycle.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      imm_src_q    <= 2'b00;
      alu_src_q    <= 2'b00;
      reg_src_q    <= 2'b00;
      alu_ctrl_q   <= 3'b000;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      imm_src_q    <= imm_src_d;
      alu_src_q    <= alu_src_d;
      reg_src_q    <= reg_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
    end
  end

  assign RegWrite   = reg_write_q;
  assign MemWrite   = mem_write_q;
  assign MemToReg   = mem_to_reg_q;
  assign ImmSrc     = imm_src_q;
  assign ALUSrc     = alu_src_q;
  assign RegSrc     = reg_src_q;
  assign ALUControl = alu_ctrl_q;

endmodule

// File: tb/tb_vector_control_unit.sv
// Directed bench for vector_control_unit: hand-computed control words per instruction.
module tb_vector_control_unit;

  logic        Clock;
  logic        reset;
  logic [17:0] Instr;
  logic        RegWrite, MemWrite, MemToReg;
  logic [1:0]  ImmSrc, ALUSrc, RegSrc;
  logic [2:0]  ALUControl;

  int errors = 0;
  int checks = 0;

  vector_control_unit #(.INSTR_W(18)) dut (
    .Clock      (Clock),
    .reset      (reset),
    .Instr      (Instr),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .ImmSrc     (ImmSrc),
    .ALUSrc     (ALUSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packed control word: {RegWrite, MemWrite, MemToReg, ImmSrc, ALUSrc, RegSrc, ALUControl}
  function automatic logic [11:0] ctrl_word();
    return {RegWrite, MemWrite, MemToReg, ImmSrc, ALUSrc, RegSrc, ALUControl};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input string tag, input logic [17:0] ins, input logic [11:0] exp);
    @(negedge Clock);
    Instr = ins;
    @(posedge Clock);
    #1;
    chk(tag, ctrl_word(), exp);
  endtask

  localparam logic [11:0] ZERO = 12'b0_0_0_00_00_00_000;
  localparam logic [11:0] RT   = 12'b1_0_0_11_00_00_000;
  localparam logic [11:0] MOV  = 12'b1_0_0_00_11_00_010;
  localparam logic [11:0] LDR  = 12'b1_0_1_01_00_00_111;
  localparam logic [11:0] STR  = 12'b0_1_0_01_00_10_111;

  initial begin
    reset = 1'b1;
    Instr = 18'h00333;
    #2;
    chk("reset_async", ctrl_word(), ZERO);
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_held", ctrl_word(), ZERO);

    @(negedge Clock);
    reset = 1'b0;
    @(posedge Clock);
    #1;
    chk("add_after_release", ctrl_word(), RT);

    apply("sub",  18'h01333, RT | 12'd1);
    apply("mul",  18'h03333, RT | 12'd3);
    apply("div",  18'h04333, RT | 12'd4);
    apply("cmp",  18'h05333, RT | 12'd5);
    apply("rt_f010", 18'h02333, RT | 12'd2);
    apply("rt_f110", 18'h06333, RT | 12'd6);
    apply("rt_f111", 18'h07333, RT | 12'd7);
    apply("add_hibits", 18'h38FB3, RT);
    apply("mov",  18'b001010000010000000, MOV);
    apply("ldr",  18'b010001000001111000, LDR);
    apply("ldr_f3_ignored", 18'b010101000001111000, LDR);
    apply("str",  18'b010000000010000010, STR);
    apply("str_f3_ignored", 18'b010111000010000010, STR);
    apply("unknown_7f", 18'h0007F, ZERO);
    apply("unknown_01", 18'h05001, ZERO);

    // Mid-cycle input change must not reach the outputs before the next edge.
    apply("ldr_before_change", 18'b010001000001111000, LDR);
    @(negedge Clock);
    Instr = 18'b010000000010000010;
    #2;
    chk("mid_cycle_hold", ctrl_word(), LDR);
    @(posedge Clock);
    #1;
    chk("mid_cycle_edge", ctrl_word(), STR);

    // Reset asserted mid-stream clears immediately, then first edge decodes current Instr.
    apply("mov_before_reset", 18'b001010000010000000, MOV);
    @(negedge Clock);
    reset = 1'b1;
    #1;
    chk("reset_midstream", ctrl_word(), ZERO);
    Instr = 18'h04333;
    @(negedge Clock);
    reset = 1'b0;
    #1;
    chk("reset_released_noedge", ctrl_word(), ZERO);
    @(posedge Clock);
    #1;
    chk("first_edge_after_reset", ctrl_word(), RT | 12'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
